csi_frame_packer: RTL



---
 rtl/csi_frame_packer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/csi_frame_packer.sv
// Ping-pong CSI frame buffer: packs each equalizer frame into one 32-bit AXI-Stream
// packet (header word + one {re,im} word per subcarrier), dropping frames it cannot hold.
module csi_frame_packer #(
    parameter int MAX_SAMPLES = 64
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               csi_axis_tvalid,
    input  logic               csi_axis_tlast,
    input  logic signed [15:0] csi_re_axis_tdata,
    input  logic signed [15:0] csi_im_axis_tdata,
    output logic               csi_axis_tready,
    output logic               m_axis_tvalid,
    output logic [31:0]        m_axis_tdata,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready,
    output logic [15:0]        frame_count_out,
    output logic [15:0]        drop_count_out
);

    localparam int         AW      = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1;
    localparam int         DEPTH   = 1 << AW;
    localparam logic [8:0] MAX_CNT = 9'(MAX_SAMPLES);

    typedef enum logic [1:0] {WR_IDLE, WR_FILL, WR_DISCARD} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_HEADER, RD_PAYLOAD} rd_state_t;

    logic [31:0] mem_q [2][DEPTH];
    logic [7:0]  bank_len_q [2];
    logic [1:0]  bank_full_q;

    wr_state_t   wr_state_q;
    logic        wr_bank_q;
    logic [8:0]  wr_cnt_q;
    logic [15:0] drop_cnt_q;
    logic        tready_q;

    rd_state_t   rd_state_q;
    logic        rd_bank_q;
    logic [7:0]  rd_idx_q;
    logic [15:0] frame_cnt_q;
    logic        m_tvalid_q;
    logic        m_tlast_q;
    logic [31:0] m_tdata_q;

    logic          beat_d;
    logic          mem_we_d;
    logic          commit_d;
    logic          drop_d;
    logic          free_d;
    logic [AW-1:0] wr_addr_d;
    logic [7:0]    wr_len_d;
    logic [AW-1:0] rd_addr_d;
    logic [7:0]    rd_len_d;
    logic [31:0]   rd_word_d;

    always_comb begin
        beat_d    = csi_axis_tvalid & tready_q;
        mem_we_d  = 1'b0;
        commit_d  = 1'b0;
        drop_d    = 1'b0;
        wr_addr_d = wr_cnt_q[AW-1:0];
        wr_len_d  = wr_cnt_q[7:0] + 8'd1;
        case (wr_state_q)
            WR_IDLE: begin
                wr_addr_d = '0;
                wr_len_d  = 8'd1;
                if (beat_d) begin
                    if (!bank_full_q[wr_bank_q]) begin
                        mem_we_d = 1'b1;
                        commit_d = csi_axis_tlast;
                    end else begin
                        drop_d = csi_axis_tlast;
                    end
                end
            end
            WR_FILL: begin
                if (beat_d) begin
                    // A beat arriving with the bank already holding MAX_SAMPLES is an overflow
                    if (wr_cnt_q == MAX_CNT) begin
                        drop_d = csi_axis_tlast;
                    end else begin
                        mem_we_d = 1'b1;
                        commit_d = csi_axis_tlast;
                    end
                end
            end
            WR_DISCARD: drop_d = beat_d & csi_axis_tlast;
            default: ;
        endcase

        rd_len_d  = bank_len_q[rd_bank_q];
        rd_addr_d = (rd_state_q == RD_HEADER) ? '0 : rd_idx_q[AW-1:0];
        rd_word_d = mem_q[rd_bank_q][rd_addr_d];
        free_d    = (rd_state_q == RD_PAYLOAD) & m_tvalid_q & m_axis_tready & m_tlast_q;
    end

    always_ff @(posedge clk_in) begin
        if (mem_we_d) mem_q[wr_bank_q][wr_addr_d] <= {csi_re_axis_tdata, csi_im_axis_tdata};
        if (commit_d) bank_len_q[wr_bank_q] <= wr_len_d;
    end

    // Set by the writer on commit, cleared by the reader on the final handshake; never the same bank
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bank_full_q <= 2'b00;
        end else begin
            if (commit_d) bank_full_q[wr_bank_q] <= 1'b1;
            if (free_d)   bank_full_q[rd_bank_q] <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_state_q <= WR_IDLE;
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
            tready_q   <= 1'b0;
        end else begin
            tready_q <= 1'b1;
            if (commit_d) wr_bank_q <= ~wr_bank_q;
            if (drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            case (wr_state_q)
                WR_IDLE: begin
                    if (beat_d && !csi_axis_tlast) begin
                        if (!bank_full_q[wr_bank_q]) begin
                            wr_cnt_q   <= 9'd1;
                            wr_state_q <= WR_FILL;
                        end else begin
                            wr_state_q <= WR_DISCARD;
                        end
                    end
                end
                WR_FILL: begin
                    if (beat_d) begin
                        if (csi_axis_tlast)            wr_state_q <= WR_IDLE;
                        else if (wr_cnt_q == MAX_CNT)  wr_state_q <= WR_DISCARD;
                        else                           wr_cnt_q   <= wr_cnt_q + 9'd1;
                    end
                end
                WR_DISCARD: begin
                    if (beat_d && csi_axis_tlast) wr_state_q <= WR_IDLE;
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    // Output register is reloaded only when empty or accepted, keeping data stable under stall
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_state_q  <= RD_IDLE;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            frame_cnt_q <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tdata_q   <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (bank_full_q[rd_bank_q]) begin
                        m_tvalid_q <= 1'b1;
                        m_tdata_q  <= {8'hC5, rd_len_d, frame_cnt_q};
                        m_tlast_q  <= 1'b0;
                        rd_state_q <= RD_HEADER;
                    end
                end
                RD_HEADER: begin
                    if (m_axis_tready) begin
                        m_tdata_q  <= rd_word_d;
                        m_tlast_q  <= (rd_len_d == 8'd1);
                        rd_idx_q   <= 8'd1;
                        rd_state_q <= RD_PAYLOAD;
                    end
                end
                RD_PAYLOAD: begin
                    if (m_axis_tready) begin
                        if (m_tlast_q) begin
                            m_tvalid_q  <= 1'b0;
                            m_tlast_q   <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            rd_bank_q   <= ~rd_bank_q;
                            rd_state_q  <= RD_IDLE;
                        end else begin
                            m_tdata_q <= rd_word_d;
                            m_tlast_q <= (rd_idx_q == rd_len_d - 8'd1);
                            rd_idx_q  <= rd_idx_q + 8'd1;
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign csi_axis_tready = tready_q;
    assign m_axis_tvalid   = m_tvalid_q;
    assign m_axis_tdata    = m_tdata_q;
    assign m_axis_tlast    = m_tlast_q;
    assign frame_count_out = frame_cnt_q;
    assign drop_count_out  = drop_cnt_q;

endmodule
